// File: rtl/zle_xcb_arb2_pkg.sv
// Shared types and constants for the two-channel frame arbiter in front of the zle_xcB encoder.
package zle_xcb_arb2_pkg;

    localparam int DW_DEF    = 7;
    localparam int FRAME_DEF = 16;
    localparam int CW_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

    localparam logic [1:0] GRANT_IDLE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

endpackage

// File: rtl/zle_xcb_arb2_frame_cnt.sv
// Counts transfers inside the current frame (0..FRAME-1) and flags the first and last slot.
module zle_xcb_arb2_frame_cnt #(
    parameter int CW    = 8,
    parameter int FRAME = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_first,
    output logic o_at_last
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_at_first = (r_cnt == '0);
    assign o_at_last  = (r_cnt == CW'(FRAME - 1));

endmodule

// File: rtl/zle_xcb_arb2.sv
// Frame-granular arbiter: hands the shared encoder input to channel A or B for whole frames.
module zle_xcb_arb2
    import zle_xcb_arb2_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int FRAME = FRAME_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] a_d,
    input  logic          a_v,
    output logic          a_b,
    input  logic [DW-1:0] b_d,
    input  logic          b_v,
    output logic          b_b,
    output logic [DW-1:0] z_d,
    output logic          z_v,
    input  logic          z_b,
    output logic [1:0]    grant,
    output logic          frame_done,
    output logic          frm_err
);

    state_t r_state;
    state_t w_next;
    chan_t  r_last;
    logic   r_frame_done;
    logic   r_frm_err;
    logic   w_xfer;
    logic   w_at_first;
    logic   w_at_last;
    logic   w_frame_end;

    assign w_xfer      = z_v & ~z_b;
    assign w_frame_end = w_xfer & w_at_last;

    zle_xcb_arb2_frame_cnt #(
        .CW    (CW),
        .FRAME (FRAME)
    ) u_frame_cnt (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (w_xfer & ~w_at_last),
        .i_clr      (w_frame_end),
        .o_at_first (w_at_first),
        .o_at_last  (w_at_last)
    );

    always_comb begin
        z_d = '0;
        z_v = 1'b0;
        a_b = 1'b1;
        b_b = 1'b1;
        unique case (r_state)
            ST_GNT_A: begin
                z_d = a_d;
                z_v = a_v;
                a_b = z_b;
            end
            ST_GNT_B: begin
                z_d = b_d;
                z_v = b_v;
                b_b = z_b;
            end
            default: ;
        endcase
    end

    always_comb begin
        grant = GRANT_IDLE;
        unique case (r_state)
            ST_GNT_A: grant = GRANT_A;
            ST_GNT_B: grant = GRANT_B;
            default:  grant = GRANT_IDLE;
        endcase
    end

    // A switch is only allowed before a frame's first token or right at its end.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (a_v && b_v) begin
                    w_next = (r_last == CH_B) ? ST_GNT_A : ST_GNT_B;
                end else if (a_v) begin
                    w_next = ST_GNT_A;
                end else if (b_v) begin
                    w_next = ST_GNT_B;
                end
            end
            ST_GNT_A: begin
                if (w_frame_end) begin
                    if (b_v) begin
                        w_next = ST_GNT_B;
                    end
                end else if (w_at_first && !a_v && b_v) begin
                    w_next = ST_GNT_B;
                end
            end
            ST_GNT_B: begin
                if (w_frame_end) begin
                    if (a_v) begin
                        w_next = ST_GNT_A;
                    end
                end else if (w_at_first && !b_v && a_v) begin
                    w_next = ST_GNT_A;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last       <= CH_B;
            r_frame_done <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_last <= (r_state == ST_GNT_B) ? CH_B : CH_A;
                if (z_d == '0) begin
                    r_frm_err <= 1'b1;
                end
            end
        end
    end

    assign frame_done = r_frame_done;
    assign frm_err    = r_frm_err;

endmodule

// File: tb/tb_zle_xcb_arb2.sv
// Directed bench for zle_xcb_arb2 with a per-cycle behavioural model and hand-computed checkpoints.
module tb_zle_xcb_arb2;

    localparam int DW    = 7;
    localparam int FRAME = 16;
    localparam int CW    = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] a_d   = '0;
    logic          a_v   = 1'b0;
    logic [DW-1:0] b_d   = '0;
    logic          b_v   = 1'b0;
    logic          z_b   = 1'b0;
    logic          a_b;
    logic          b_b;
    logic [DW-1:0] z_d;
    logic          z_v;
    logic [1:0]    grant;
    logic          frame_done;
    logic          frm_err;

    int checks    = 0;
    int failures  = 0;
    int doneSeen  = 0;
    bit checkEn   = 1'b0;

    // Model state: owner 0=none 1=A 2=B, last 1=A 2=B
    int mOwner = 0;
    int mCnt   = 0;
    int mLast  = 2;
    bit mErr   = 1'b0;
    bit mDone  = 1'b0;

    zle_xcb_arb2 #(.DW(DW), .FRAME(FRAME), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .a_d        (a_d),
        .a_v        (a_v),
        .a_b        (a_b),
        .b_d        (b_d),
        .b_v        (b_v),
        .b_b        (b_b),
        .z_d        (z_d),
        .z_v        (z_v),
        .z_b        (z_b),
        .grant      (grant),
        .frame_done (frame_done),
        .frm_err    (frm_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic aV, input logic [DW-1:0] aD,
                                 input logic bV, input logic [DW-1:0] bD, input logic zB);
        a_v = aV;
        a_d = aD;
        b_v = bV;
        b_d = bD;
        z_b = zB;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        reset = 1'b0;
    endtask

    // Frame rules: tie goes away from last served, mid-frame holds, frame end hands over if other waits.
    always @(posedge clock) begin : modelUpdate
        bit            ownV;
        bit            othV;
        bit            moved;
        bit            ends;
        logic [DW-1:0] ownD;
        int            other;
        ownV  = (mOwner == 1) ? a_v : (mOwner == 2) ? b_v : 1'b0;
        othV  = (mOwner == 1) ? b_v : (mOwner == 2) ? a_v : 1'b0;
        ownD  = (mOwner == 1) ? a_d : b_d;
        other = 3 - mOwner;
        moved = (mOwner != 0) && ownV && !z_b;
        ends  = moved && (mCnt == FRAME - 1);
        if (reset) begin
            mOwner <= 0;
            mCnt   <= 0;
            mLast  <= 2;
            mErr   <= 1'b0;
            mDone  <= 1'b0;
        end else begin
            mDone <= ends;
            if (mOwner == 0) begin
                if (a_v && b_v)  mOwner <= (mLast == 1) ? 2 : 1;
                else if (a_v)    mOwner <= 1;
                else if (b_v)    mOwner <= 2;
            end else if (ends) begin
                mCnt  <= 0;
                mLast <= mOwner;
                if (ownD == '0) mErr <= 1'b1;
                if (othV) mOwner <= other;
            end else if (moved) begin
                mCnt <= mCnt + 1;
            end else if (mCnt == 0 && !ownV && othV) begin
                mOwner <= other;
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [DW-1:0] eD;
        logic          eV;
        logic          eAB;
        logic          eBB;
        logic [1:0]    eG;
        eD  = '0;
        eV  = 1'b0;
        eAB = 1'b1;
        eBB = 1'b1;
        eG  = 2'b00;
        if (mOwner == 1) begin
            eD = a_d; eV = a_v; eAB = z_b; eG = 2'b01;
        end else if (mOwner == 2) begin
            eD = b_d; eV = b_v; eBB = z_b; eG = 2'b10;
        end
        if (checkEn) begin
            checkOutput("grant", 32'(grant), 32'(eG));
            checkOutput("z_v", 32'(z_v), 32'(eV));
            checkOutput("z_d", 32'(z_d), 32'(eD));
            checkOutput("a_b", 32'(a_b), 32'(eAB));
            checkOutput("b_b", 32'(b_b), 32'(eBB));
            checkOutput("frame_done", 32'(frame_done), 32'(mDone));
            checkOutput("frm_err", 32'(frm_err), 32'(mErr));
            if (frame_done === 1'b1) doneSeen++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int d0;
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkEn = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_a_b", 32'(a_b), 32'h1);
        checkOutput("rst_b_b", 32'(b_b), 32'h1);
        checkOutput("rst_z_v", 32'(z_v), 32'h0);
        checkOutput("rst_frm_err", 32'(frm_err), 32'h0);
        reset = 1'b0;

        // A streams one frame, B idle
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("t1_done_count", 32'(doneSeen), 32'd1);
        checkOutput("t1_grant_hold", 32'(grant), 32'h1);

        // Both continuous from reset: A first, then alternate per frame
        doReset();
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 7'h11, 1'b1, 7'h22, 1'b0);
        checkOutput("t2_grant_b", 32'(grant), 32'h2);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 7'h11, 1'b1, 7'h22, 1'b0);
        checkOutput("t2_grant_a", 32'(grant), 32'h1);

        // Mid-frame valid gap on A while B waits
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 7'h33, 1'b0);
        checkOutput("t3_gap_hold", 32'(grant), 32'h1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(i + 20), 1'b1, 7'h33, 1'b0);
        checkOutput("t3_pre_switch", 32'(grant), 32'h1);
        applyStimulus(1'b1, 7'h44, 1'b1, 7'h33, 1'b0);
        checkOutput("t3_switch", 32'(grant), 32'h2);

        // Frame boundary with A silent and B requesting
        doReset();
        applyStimulus(1'b1, 7'h05, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 7'h05, 1'b0);
        checkOutput("t4_switch", 32'(grant), 32'h2);

        // Encoder stall on the last slot of a frame
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, '0, 1'b0);
        d0 = doneSeen;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 7'h10, 1'b0, '0, 1'b1);
        checkOutput("t5_stall_a_b", 32'(a_b), 32'h1);
        checkOutput("t5_no_done", 32'(doneSeen), 32'(d0));
        applyStimulus(1'b1, 7'h10, 1'b0, '0, 1'b0);
        checkOutput("t5_done_pulse", 32'(frame_done), 32'h1);

        // Zero final token sets sticky error; reset mid-frame clears everything
        doReset();
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, (i == 16) ? 7'h00 : DW'(i + 1), 1'b0, '0, 1'b0);
        checkOutput("t6_err_set", 32'(frm_err), 32'h1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 7'h2A, 1'b0, '0, 1'b0);
        checkOutput("t6_err_sticky", 32'(frm_err), 32'h1);
        reset = 1'b1;
        applyStimulus(1'b1, 7'h2A, 1'b0, '0, 1'b0);
        checkOutput("t6_rst_grant", 32'(grant), 32'h0);
        checkOutput("t6_rst_err", 32'(frm_err), 32'h0);
        reset = 1'b0;
        d0 = doneSeen;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(i + 1), 1'b0, '0, 1'b0);
        checkOutput("t6_cnt_restart", 32'(doneSeen), 32'(d0));
        applyStimulus(1'b1, 7'h01, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("t6_full_frame", 32'(doneSeen), 32'(d0 + 1));

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
